// File: rtl/tcdm_error_responder_pkg.sv
// Shared types for the interconnect error responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pkg_soc_interconnect;

  // Poison word returned on every error response.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

  // Snapshot of the first offending access.
  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  be;
  } err_info_t;

  typedef enum logic {
    ERR_IDLE,
    ERR_LOCKED
  } err_state_e;

endpackage

// File: rtl/tcdm_error_responder_if.sv
// TCDM crossbar bus: request channel plus one-beat response channel.
// Latency: n/a (signal bundle only).
// Backpressure: gnt qualifies req; the response channel has no ready.
// Ports: req/add/wen/wdata/be (master->slave), gnt/r_valid/r_opc/r_rdata (slave->master).
interface XBAR_TCDM_BUS;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic        r_opc;
  logic [31:0] r_rdata;

  modport Master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_opc, r_rdata
  );

  modport Slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_opc, r_rdata
  );
endinterface

// File: rtl/tcdm_error_responder_err_counter.sv
// Saturating event counter with synchronous clear and sticky overflow flag.
// Latency: count and overflow update one cycle after inc_i / clr_i.
// Backpressure: none; every inc_i is accepted.
// Ports: clk_i, rst_ni, inc_i, clr_i in; cnt_o, ovf_o out.
module tcdm_err_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      // Clear wins, but an increment in the same cycle still counts as the
      // first event after the clear.
      cnt_q <= CNT_WIDTH'(inc_i);
      ovf_q <= 1'b0;
    end else if (inc_i) begin
      if (cnt_q == CNT_MAX) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/tcdm_error_responder.sv
// Terminating TCDM slave on the crossbar error port: grants all requests and
// answers each with an error beat, counting errors and capturing the first one.
// Latency: response, status and interrupt one cycle after req&gnt.
// Backpressure: none; gnt = req combinationally.
// Ports: clk_i, rst_ni, test_en_i, clr_i; tcdm_slave (XBAR_TCDM_BUS.Slave);
//        err_irq_o, err_addr_o, err_wen_o, err_be_o, err_cnt_o, err_ovf_o.
// Macro TCDM_ERR_CAPTURE_EN: enables first-error capture FSM; otherwise the
// capture outputs are tied 0 and err_irq_o flags a non-zero error count.
module tcdm_error_responder
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 test_en_i,
  XBAR_TCDM_BUS.Slave          tcdm_slave,
  input  logic                 clr_i,
  output logic                 err_irq_o,
  output logic [31:0]          err_addr_o,
  output logic                 err_wen_o,
  output logic [3:0]           err_be_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o,
  output logic                 err_ovf_o
);

  logic        hit;
  logic        r_valid_q;
  logic        r_opc_q;
  logic [31:0] r_rdata_q;
  logic        irq_q;

  assign tcdm_slave.gnt = tcdm_slave.req;
  assign hit            = tcdm_slave.req & tcdm_slave.gnt;

  // Write data and test mode carry no meaning for an error sink.
  logic unused_inputs;
  assign unused_inputs = ^{tcdm_slave.wdata, test_en_i};

  // Response beat: opc/rdata are forced to zero whenever no beat is valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_opc_q   <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      r_valid_q <= hit;
      r_opc_q   <= hit;
      r_rdata_q <= hit ? ERR_RDATA : '0;
    end
  end

  assign tcdm_slave.r_valid = r_valid_q;
  assign tcdm_slave.r_opc   = r_opc_q;
  assign tcdm_slave.r_rdata = r_rdata_q;

  tcdm_err_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) i_err_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (hit),
    .clr_i  (clr_i),
    .cnt_o  (err_cnt_o),
    .ovf_o  (err_ovf_o)
  );

`ifdef TCDM_ERR_CAPTURE_EN
  err_state_e state_q;
  err_info_t  cap_q;

  // Later assignments override the clear, so a request arriving together
  // with clr_i becomes the new first error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ERR_IDLE;
      cap_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (clr_i) begin
        state_q <= ERR_IDLE;
        cap_q   <= '0;
        irq_q   <= 1'b0;
      end
      if (hit && (clr_i || state_q == ERR_IDLE)) begin
        state_q <= ERR_LOCKED;
        cap_q   <= '{addr: tcdm_slave.add, wen: tcdm_slave.wen, be: tcdm_slave.be};
        irq_q   <= 1'b1;
      end
    end
  end

  assign err_addr_o = cap_q.addr;
  assign err_wen_o  = cap_q.wen;
  assign err_be_o   = cap_q.be;
`else
  // Registered from the counter's next value so the interrupt lines up with
  // the count update rather than lagging it by a cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else if (clr_i) begin
      irq_q <= hit;
    end else begin
      irq_q <= hit || (err_cnt_o != '0);
    end
  end

  logic unused_capture;
  assign unused_capture = ^{tcdm_slave.add, tcdm_slave.wen, tcdm_slave.be};

  assign err_addr_o = '0;
  assign err_wen_o  = 1'b0;
  assign err_be_o   = '0;
`endif

  assign err_irq_o = irq_q;

endmodule

// File: tb/tb_tcdm_error_responder.sv
module tb_tcdm_error_responder;

  localparam int unsigned CW    = 2;
  localparam int          MAXC  = (1 << CW) - 1;
  localparam logic [31:0] POISON = 32'hBADACCE5;

  logic          clk;
  logic          rst_ni;
  logic          test_en;
  logic          clr;
  logic          irq;
  logic [31:0]   eaddr;
  logic          ewen;
  logic [3:0]    ebe;
  logic [CW-1:0] ecnt;
  logic          eovf;

  XBAR_TCDM_BUS bus();

  tcdm_error_responder #(
    .CNT_WIDTH (CW),
    .ERR_RDATA (POISON)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .test_en_i  (test_en),
    .tcdm_slave (bus),
    .clr_i      (clr),
    .err_irq_o  (irq),
    .err_addr_o (eaddr),
    .err_wen_o  (ewen),
    .err_be_o   (ebe),
    .err_cnt_o  (ecnt),
    .err_ovf_o  (eovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected DUT view in a given cycle.
  typedef struct {
    int          cyc;
    bit          rv;
    bit          irq;
    logic [31:0] addr;
    bit          wen;
    logic [3:0]  be;
    int          cnt;
    bit          ovf;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mon_en  = 1'b0;

  // Reference model: plain description of the error bookkeeping.
  int          m_cnt;
  bit          m_ovf;
  bit          m_locked;
  logic [31:0] m_addr;
  bit          m_wen;
  logic [3:0]  m_be;

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_locked = 0; m_addr = '0; m_wen = 0; m_be = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One bus cycle of stimulus; the expectation is for the cycle after sampling.
  task automatic drive(input bit rq, input logic [31:0] a, input bit w,
                       input logic [3:0] b, input bit c);
    exp_t e;
    @(posedge clk);
    #1;
    bus.req   = rq;
    bus.add   = a;
    bus.wen   = w;
    bus.be    = b;
    bus.wdata = $urandom;
    clr       = c;
    if (c) begin
      m_cnt = 0; m_ovf = 0; m_locked = 0; m_addr = '0; m_wen = 0; m_be = '0;
    end
    if (rq) begin
      if (m_cnt == MAXC) m_ovf = 1;
      else m_cnt = m_cnt + 1;
      if (!m_locked) begin
        m_locked = 1; m_addr = a; m_wen = w; m_be = b;
      end
    end
    e.cyc = cyc + 1;
    e.rv  = rq;
    e.cnt = m_cnt;
    e.ovf = m_ovf;
`ifdef TCDM_ERR_CAPTURE_EN
    e.irq = m_locked; e.addr = m_addr; e.wen = m_wen; e.be = m_be;
`else
    e.irq = (m_cnt != 0); e.addr = '0; e.wen = 0; e.be = '0;
`endif
    q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  // Monitor: checks the grant path and consumes expectations as they fall due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("gnt", {31'b0, bus.gnt}, {31'b0, bus.req});
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("sync",    cyc,                        e.cyc);
          chk("r_valid", {31'b0, bus.r_valid},       {31'b0, e.rv});
          chk("r_opc",   {31'b0, bus.r_opc},         {31'b0, e.rv});
          chk("r_rdata", bus.r_rdata,                e.rv ? POISON : 32'h0);
          chk("irq",     {31'b0, irq},               {31'b0, e.irq});
          chk("addr",    eaddr,                      e.addr);
          chk("wen",     {31'b0, ewen},              {31'b0, e.wen});
          chk("be",      {28'b0, ebe},               {28'b0, e.be});
          chk("cnt",     {{(32-CW){1'b0}}, ecnt},    e.cnt);
          chk("ovf",     {31'b0, eovf},              {31'b0, e.ovf});
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_r_valid"}, {31'b0, bus.r_valid}, 32'h0);
    chk({tag, "_r_opc"},   {31'b0, bus.r_opc},   32'h0);
    chk({tag, "_r_rdata"}, bus.r_rdata,          32'h0);
    chk({tag, "_irq"},     {31'b0, irq},         32'h0);
    chk({tag, "_addr"},    eaddr,                32'h0);
    chk({tag, "_wen"},     {31'b0, ewen},        32'h0);
    chk({tag, "_be"},      {28'b0, ebe},         32'h0);
    chk({tag, "_cnt"},     {{(32-CW){1'b0}}, ecnt}, 32'h0);
    chk({tag, "_ovf"},     {31'b0, eovf},        32'h0);
  endtask

  initial begin
    rst_ni = 1'b0; test_en = 1'b0; clr = 1'b0;
    bus.req = 1'b0; bus.add = '0; bus.wen = 1'b0; bus.wdata = '0; bus.be = '0;
    model_reset();
    #3;
    chk_all_zero("reset");
    bus.req = 1'b1;
    #1;
    chk("reset_gnt", {31'b0, bus.gnt}, 32'h1);
    bus.req = 1'b0;
    #8;
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Single read: first capture.
    drive(1'b1, 32'h1C00_0040, 1'b1, 4'hF, 1'b0);
    idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
    // Back-to-back writes: first one stays captured.
    drive(1'b1, 32'h2000_0000, 1'b0, 4'h3, 1'b0);
    drive(1'b1, 32'h3000_0000, 1'b0, 4'hC, 1'b0);
    idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
    // Saturation: five requests on a 2-bit counter.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h4000_0000 + 32'(i * 4), 1'b1, 4'h1, 1'b0);
    idle();
    idle();
    // Clear together with a request re-arms capture on that request.
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
    drive(1'b1, 32'h0000_0100, 1'b1, 4'hF, 1'b0);
    drive(1'b1, 32'h0000_0200, 1'b0, 4'h5, 1'b1);
    idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
    idle();

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, 1'($urandom), 4'($urandom),
            ($urandom_range(0, 19) == 0));
    end
    idle();
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    // Reset while a response is on the bus.
    drive(1'b1, 32'h0000_0600, 1'b1, 4'hF, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("pre_rst_r_valid", {31'b0, bus.r_valid}, 32'h1);
    bus.req = 1'b0;
    q.delete();
    rst_ni = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d expected < 20000", cyc);
    $fatal(1, "timeout");
  end

endmodule
